// File: rtl/core_pkg.sv
// core_pkg: shared core constants (register file defaults, x0 index, major opcodes).
package core_pkg;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_X0 = 0;
  typedef enum logic [6:0] {
    R_TYPE = 7'b0110011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011
  } opcode_e;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for in-flight writes, with issue/clear/flush priority and WAW stall.
module regfile_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NREGS  = core_pkg::NREGS,
  localparam int unsigned AW    = $clog2(NREGS),
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          reg_write,
  input  logic [AW-1:0] rd,
  input  logic          flush,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          issue_stall
);
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic             w_issue_nz;
  logic             w_accept;
  assign w_issue_nz  = issue_rd != AW'(REG_X0);
  // A producer committing to the same register this cycle resolves the WAW hazard.
  assign issue_stall = issue_valid && w_issue_nz && r_busy[issue_rd] && !(reg_write && rd == issue_rd);
  assign w_accept    = issue_valid && !issue_stall && w_issue_nz;
  assign w_set       = w_accept ? NREGS'(1) << issue_rd : '0;
  assign w_clr       = reg_write ? NREGS'(1) << rd : '0;
  assign rs1_busy    = r_busy[rs1] && !(BYPASS && reg_write && rd == rs1);
  assign rs2_busy    = r_busy[rs2] && !(BYPASS && reg_write && rd == rs2);
  // Set after clear so a new producer issued on the commit edge keeps the bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_busy <= '0;
    else        r_busy <= flush ? '0 : (r_busy & ~w_clr) | w_set;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/1-write register file with x0 hardwired to zero, writeback bypass
// and an in-flight-write scoreboard.
module regfile_sb
  import core_pkg::*;
#(
  parameter int unsigned XLEN   = core_pkg::XLEN,
  parameter int unsigned NREGS  = core_pkg::NREGS,
  localparam int unsigned AW    = $clog2(NREGS),
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_stall,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            flush
);
  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_we;
  assign w_we = reg_write && rd != AW'(REG_X0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    else if (w_we) r_regs[rd] <= write_data;
  assign read_data1 = (rs1 == AW'(REG_X0)) ? '0 :
                      (BYPASS && w_we && rd == rs1) ? write_data : r_regs[rs1];
  assign read_data2 = (rs2 == AW'(REG_X0)) ? '0 :
                      (BYPASS && w_we && rd == rs2) ? write_data : r_regs[rs2];
  regfile_scoreboard #(.NREGS(NREGS), .BYPASS(BYPASS)) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1         (rs1),
    .rs2         (rs2),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .reg_write   (reg_write),
    .rd          (rd),
    .flush       (flush),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .issue_stall (issue_stall)
  );
endmodule
